// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states,
// word geometry and the opcode used to build the halt word.
package loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_HALT,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [5:0] HALT_OPCODE    = 6'b111111;
    localparam int         BYTES_PER_WORD = 4;

    // Places byte b into the big-endian lane idx of word (lane 0 = bits 31:24).
    function automatic logic [31:0] insertByte(input logic [31:0] word,
                                               input logic [1:0]  idx,
                                               input logic [7:0]  b);
        logic [31:0] result;
        result = word;
        case (idx)
            2'd0:    result[31:24] = b;
            2'd1:    result[23:16] = b;
            2'd2:    result[15:8]  = b;
            default: result[7:0]   = b;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/byte_packer.sv
// Collects accepted bytes big-endian into a 32-bit word. A word is presented
// (o_wordReady high for one cycle) the cycle after its fourth byte, or after a
// byte flagged last, in which case the unused low lanes are zero.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_accept,
    input  logic [7:0]  i_byte,
    input  logic        i_last,
    output logic        o_wordReady,
    output logic [31:0] o_word
);

    logic [1:0]  r_count;
    logic [31:0] r_shift;
    logic [31:0] r_word;
    logic        r_ready;

    logic [31:0] w_inserted;
    logic        w_wordEnd;

    // Merge the incoming byte into the partial word and decide whether it closes the word.
    always_comb begin
        w_inserted = insertByte(r_shift, r_count, i_byte);
        w_wordEnd  = (r_count == 2'(BYTES_PER_WORD - 1)) || i_last;
    end

    // Byte counter, partial-word register and the one-cycle completed-word output.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
            r_shift <= '0;
            r_word  <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            if (i_accept) begin
                if (w_wordEnd) begin
                    r_word  <= w_inserted;
                    r_ready <= 1'b1;
                    r_shift <= '0;
                    r_count <= '0;
                end else begin
                    r_shift <= w_inserted;
                    r_count <= r_count + 2'd1;
                end
            end
        end
    end

    assign o_wordReady = r_ready;
    assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// Writer side of the instruction-memory interface: packs a byte stream into
// words, writes them to consecutive imem addresses, optionally appends a halt
// word, then releases the core with cpu_run and pc_init.
module imem_loader
    import loader_pkg::*;
#(
    parameter int          ADDR_W      = 6,
    parameter logic [31:0] START_PC    = 32'h0000_0000,
    parameter int          APPEND_HALT = 1,
    parameter logic [31:0] HALT_WORD   = {HALT_OPCODE, 26'd0}
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_run,
    output logic [31:0]       pc_init,
    output logic              done,
    output logic              error
);

    // One extra pointer bit so that "all words written" differs from address 0.
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] PTR_FULL = (ADDR_W + 1)'(DEPTH);

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W:0]   r_wordPtr;

    logic              w_packerReady;
    logic [31:0]       w_packedWord;
    logic              w_inReady;
    logic              w_handshake;
    logic              w_full;
    logic              w_writeWord;
    logic              w_writeHalt;
    logic              w_we;
    logic [ADDR_W:0]   w_ptrEff;
    logic              w_overflow;
    logic              w_accept;

    byte_packer u_packer (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (start),
        .i_accept    (w_accept),
        .i_byte      (in_data),
        .i_last      (in_last),
        .o_wordReady (w_packerReady),
        .o_word      (w_packedWord)
    );

    // Handshake, write qualification and overflow detection. A byte is an overflow
    // if, counting a write happening this same cycle, every word is already used.
    always_comb begin
        w_inReady   = (r_state == S_LOAD) && !start;
        w_handshake = in_valid && w_inReady;
        w_full      = (r_wordPtr == PTR_FULL);
        w_writeWord = ((r_state == S_LOAD) || (r_state == S_PAD)) && w_packerReady
                      && !w_full && !start;
        w_writeHalt = (r_state == S_HALT) && !w_full && !start;
        w_we        = w_writeWord || w_writeHalt;
        w_ptrEff    = r_wordPtr + (ADDR_W + 1)'(w_we);
        w_overflow  = w_handshake && (w_ptrEff == PTR_FULL);
        w_accept    = w_handshake && !w_overflow;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; start restarts a load from any state.
    always_comb begin
        w_nextState = r_state;
        if (start) begin
            w_nextState = S_LOAD;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (w_overflow) begin
                        w_nextState = S_ERR;
                    end else if (w_accept && in_last) begin
                        w_nextState = S_PAD;
                    end
                end
                S_PAD:   w_nextState = (APPEND_HALT != 0) ? S_HALT : S_DONE;
                S_HALT:  w_nextState = S_DONE;
                default: w_nextState = r_state;
            endcase
        end
    end

    // Word pointer: cleared on reset/start, advanced after every imem write.
    always_ff @(posedge clk) begin
        if (reset || start) begin
            r_wordPtr <= '0;
        end else if (w_we) begin
            r_wordPtr <= r_wordPtr + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    // Outputs decoded from the state and the write qualifiers.
    always_comb begin
        in_ready = w_inReady;
        we       = w_we;
        waddr    = r_wordPtr[ADDR_W-1:0];
        wdata    = 32'd0;
        if (w_writeWord) begin
            wdata = w_packedWord;
        end else if (w_writeHalt) begin
            wdata = HALT_WORD;
        end
        cpu_run  = (r_state == S_DONE);
        done     = (r_state == S_DONE);
        pc_init  = (r_state == S_DONE) ? START_PC : 32'd0;
        error    = (r_state == S_ERR);
    end

endmodule
